// File: rtl/block_serial_cla_adder.sv
// Chunk-serial carry-lookahead adder/subtractor, one BLOCK-bit chunk per clock.
// Optional result saturation on signed overflow is enabled by CARRY_SAT_EN.
module block_serial_cla_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_start,
   input  logic             ctrl_sub,
`ifdef CARRY_SAT_EN
   input  logic             ctrl_sat,
`endif
   input  logic             data_cin,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_carry_bits,
   output logic             data_cout,
   output logic             data_overflow,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int N  = WIDTH / BLOCK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
`ifdef CARRY_SAT_EN
   logic              sat_q;
`endif

   logic [BLOCK-1:0]  ca;
   logic [BLOCK-1:0]  cb;
   logic [BLOCK-1:0]  gen;
   logic [BLOCK-1:0]  prop;
   logic [BLOCK-1:0]  sum_c;
   logic [BLOCK-1:0]  cy_c;
   logic              cy;
   logic              pp;
   logic [WIDTH-1:0]  res_nx;
   logic [WIDTH-1:0]  cb_nx;
   logic              ovf_nx;
   logic [WIDTH-1:0]  sat_val;

   // Each carry is a flat sum of generate terms gated by the propagate
   // run above them, so no carry depends on a neighbouring carry.
   always_comb begin
      ca    = a_q[cnt*BLOCK +: BLOCK];
      cb    = b_q[cnt*BLOCK +: BLOCK];
      gen   = ca & cb;
      prop  = ca ^ cb;
      cy_c  = '0;
      sum_c = '0;
      cy    = 1'b0;
      pp    = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
         cy = 1'b0;
         pp = 1'b1;
         for (int j = i; j >= 0; j--) begin
            cy = cy | (pp & gen[j]);
            pp = pp & prop[j];
         end
         cy_c[i] = cy | (pp & carry_q);
      end
      sum_c[0] = prop[0] ^ carry_q;
      for (int i = 1; i < BLOCK; i++) begin
         sum_c[i] = prop[i] ^ cy_c[i-1];
      end
   end

   always_comb begin
      res_nx = data_result;
      cb_nx  = data_carry_bits;
      res_nx[cnt*BLOCK +: BLOCK] = sum_c;
      cb_nx[cnt*BLOCK +: BLOCK]  = cy_c;
      ovf_nx = cb_nx[WIDTH-1] ^ cb_nx[WIDTH-2];
      // On overflow both operand signs agree, so A's sign picks the rail.
      sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         a_q             <= '0;
         b_q             <= '0;
         carry_q         <= 1'b0;
`ifdef CARRY_SAT_EN
         sat_q           <= 1'b0;
`endif
         data_result     <= '0;
         data_carry_bits <= '0;
         data_cout       <= 1'b0;
         data_overflow   <= 1'b0;
         data_resultRDY  <= 1'b0;
         busy            <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ctrl_start) begin
                  a_q             <= data_operandA;
                  b_q             <= ctrl_sub ? ~data_operandB
                                              : data_operandB;
                  carry_q         <= ctrl_sub | data_cin;
`ifdef CARRY_SAT_EN
                  sat_q           <= ctrl_sat;
`endif
                  data_result     <= '0;
                  data_carry_bits <= '0;
                  data_cout       <= 1'b0;
                  data_overflow   <= 1'b0;
                  busy            <= 1'b1;
                  cnt             <= '0;
                  state           <= RUN;
               end
            end
            RUN: begin
               data_result     <= res_nx;
               data_carry_bits <= cb_nx;
               carry_q         <= cy_c[BLOCK-1];
               cnt             <= cnt + CW'(1);
               if (cnt == LAST) begin
                  data_cout      <= cb_nx[WIDTH-1];
                  data_overflow  <= ovf_nx;
                  busy           <= 1'b0;
                  data_resultRDY <= 1'b1;
                  cnt            <= '0;
                  state          <= IDLE;
`ifdef CARRY_SAT_EN
                  if (sat_q && ovf_nx) begin
                     data_result <= sat_val;
                  end
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_serial_cla_adder.sv
// Directed-vector bench for block_serial_cla_adder at WIDTH=32, BLOCK=8.
// Expected values are hand-computed constants.
module tb_block_serial_cla_adder;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_start;
   logic        ctrl_sub;
`ifdef CARRY_SAT_EN
   logic        ctrl_sat;
`endif
   logic        data_cin;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic [31:0] data_carry_bits;
   logic        data_cout;
   logic        data_overflow;
   logic        data_resultRDY;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   block_serial_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_start     (ctrl_start),
      .ctrl_sub       (ctrl_sub),
`ifdef CARRY_SAT_EN
      .ctrl_sat       (ctrl_sat),
`endif
      .data_cin       (data_cin),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_carry_bits(data_carry_bits),
      .data_cout      (data_cout),
      .data_overflow  (data_overflow),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin,
                        input logic sat);
      data_operandA = a;
      data_operandB = b;
      ctrl_sub      = sub;
      data_cin      = cin;
`ifdef CARRY_SAT_EN
      ctrl_sat      = sat;
`else
      if (sat) $display("note: saturation request ignored in this build");
`endif
   endtask

   // Called #1 after the accept edge; returns there #1 after the RDY edge.
   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!data_resultRDY && n < 20);
      chk({tag, "_latency"}, n, 4);
   endtask

   task automatic check_out(input string tag, input logic [31:0] res,
                            input logic [31:0] cb, input logic co,
                            input logic ov);
      chk({tag, "_res"}, data_result, res);
      chk({tag, "_cbits"}, data_carry_bits, cb);
      chk({tag, "_cout"}, {31'b0, data_cout}, {31'b0, co});
      chk({tag, "_ovf"}, {31'b0, data_overflow}, {31'b0, ov});
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic sub,
                         input logic cin, input logic sat,
                         input logic [31:0] res, input logic [31:0] cb,
                         input logic co, input logic ov);
      drive(a, b, sub, cin, sat);
      ctrl_start = 1'b1;
      @(posedge clock);
      #1;
      ctrl_start = 1'b0;
      chk({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
      wait_rdy(tag);
      check_out(tag, res, cb, co, ov);
   endtask

   initial begin
      int pulses;
      reset      = 1'b1;
      ctrl_start = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      check_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
      chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      run_op("ff_p1", 32'h000000FF, 32'h1, 1'b0, 1'b0, 1'b0,
             32'h00000100, 32'h000000FF, 1'b0, 1'b0);
      run_op("wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0,
             32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op("sub5_7", 32'h5, 32'h7, 1'b1, 1'b0, 1'b0,
             32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      run_op("sub7_5", 32'h7, 32'h5, 1'b1, 1'b1, 1'b0,
             32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op("cin", 32'h1, 32'h2, 1'b0, 1'b1, 1'b0,
             32'h00000004, 32'h00000003, 1'b0, 1'b0);
      run_op("posovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0,
             32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);
      run_op("negovf", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0,
             32'h00000000, 32'h80000000, 1'b1, 1'b1);
`ifdef CARRY_SAT_EN
      run_op("sat_pos", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1,
             32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
      run_op("sat_neg", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1,
             32'h80000000, 32'h80000000, 1'b1, 1'b1);
      run_op("sat_none", 32'h000000FF, 32'h1, 1'b0, 1'b0, 1'b1,
             32'h00000100, 32'h000000FF, 1'b0, 1'b0);
`endif

      // Start while busy is ignored.
      drive(32'h000000FF, 32'h1, 1'b0, 1'b0, 1'b0);
      ctrl_start = 1'b1;
      @(posedge clock);
      #1;
      ctrl_start = 1'b0;
      @(posedge clock);
      #1;
      drive(32'h12345678, 32'h11111111, 1'b1, 1'b1, 1'b0);
      ctrl_start = 1'b1;
      @(posedge clock);
      #1;
      ctrl_start = 1'b0;
      chk("ign_busy", {31'b0, busy}, 32'd1);
      pulses = 0;
      while (!data_resultRDY && pulses < 20) begin
         @(posedge clock);
         #1;
         pulses++;
      end
      chk("ign_latency", pulses, 2);
      check_out("ign", 32'h00000100, 32'h000000FF, 1'b0, 1'b0);

      // Back-to-back start in the RDY cycle.
      drive(32'h7, 32'h5, 1'b1, 1'b0, 1'b0);
      ctrl_start = 1'b1;
      @(posedge clock);
      #1;
      ctrl_start = 1'b0;
      chk("b2b_rdy_drop", {31'b0, data_resultRDY}, 32'd0);
      chk("b2b_clr", data_result, 32'h0);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      wait_rdy("b2b");
      check_out("b2b", 32'h00000002, 32'hFFFFFFFF, 1'b1, 1'b0);

      // Reset mid-run, with a competing start.
      drive(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
      ctrl_start = 1'b1;
      @(posedge clock);
      #1;
      ctrl_start = 1'b0;
      @(posedge clock);
      #1;
      reset      = 1'b1;
      ctrl_start = 1'b1;
      drive(32'h1, 32'h1, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      reset      = 1'b0;
      ctrl_start = 1'b0;
      check_out("rst_run", 32'h0, 32'h0, 1'b0, 1'b0);
      pulses = 0;
      repeat (8) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) pulses++;
      end
      chk("rst_no_rdy", pulses, 0);
      chk("rst_idle_busy", {31'b0, busy}, 32'd0);
      run_op("fresh", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0,
             32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);

      // Outputs hold after completion.
      repeat (3) @(posedge clock);
      #1;
      chk("hold_res", data_result, 32'h0);
      chk("hold_cbits", data_carry_bits, 32'hFFFFFFFF);
      chk("hold_rdy", {31'b0, data_resultRDY}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
